// File: rtl/fifo_dac_reader.sv
// fifo_dac_reader: pops signed samples from the generator FIFO and shifts
// each one MSB-first to a serial DAC over a cs_n/sclk/sdo frame.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous reset, active-high
//   en_low_i       active-low enable (1 = stop after current frame)
//   fifo_empty_i   FIFO empty flag
//   fifo_data_i    FIFO read data, valid the cycle after fifo_rd_en_o
//   fifo_rd_en_o   one-cycle pop request per sample
//   cs_n_o         DAC chip select, active-low
//   sclk_o         DAC serial clock (DAC samples on rising edge)
//   sdo_o          DAC serial data, MSB first
//   sample_o       last sample popped (signed)
//   sample_valid_o one-cycle pulse when sample_o updates
//   busy_o         high in every state except IDLE
//   underrun_o     sticky stream-starvation flag

module fifo_dac_reader #(
   parameter int DATA_WIDTH = 16,
   parameter int DIV        = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         en_low_i,
   input  logic                         fifo_empty_i,
   input  logic [DATA_WIDTH-1:0]        fifo_data_i,
   output logic                         fifo_rd_en_o,
   output logic                         cs_n_o,
   output logic                         sclk_o,
   output logic                         sdo_o,
   output logic signed [DATA_WIDTH-1:0] sample_o,
   output logic                         sample_valid_o,
   output logic                         busy_o,
   output logic                         underrun_o
);

   localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam int PW = (2 * DIV > 1) ? $clog2(2 * DIV) : 1;

   localparam logic [BW-1:0] BIT_MSB  = BW'(DATA_WIDTH - 1);
   localparam logic [BW-1:0] BIT_LSB  = '0;
   // last phase of the low half; the next phase raises sclk
   localparam logic [PW-1:0] PH_RISE  = PW'(DIV - 1);
   localparam logic [PW-1:0] PH_LAST  = PW'(2 * DIV - 1);
   localparam logic [PW-1:0] GAP_LAST = PW'(DIV - 1);

   typedef enum logic [2:0] {
      IDLE,
      READ,
      WAIT,
      SHIFT,
      GAP
   } state_t;

   state_t                state;
   logic [BW-1:0]         bit_cnt;
   logic [PW-1:0]         phase;
   logic [DATA_WIDTH-1:0] shreg;
   logic                  frame_sent;

   logic start;
   logic starve;

   assign start  = !en_low_i && !fifo_empty_i;
   // starvation only counts once a frame has gone out since enable
   assign starve = !en_low_i && fifo_empty_i && frame_sent;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         bit_cnt        <= '0;
         phase          <= '0;
         shreg          <= '0;
         frame_sent     <= 1'b0;
         fifo_rd_en_o   <= 1'b0;
         cs_n_o         <= 1'b1;
         sclk_o         <= 1'b0;
         sdo_o          <= 1'b0;
         sample_o       <= '0;
         sample_valid_o <= 1'b0;
         busy_o         <= 1'b0;
         underrun_o     <= 1'b0;
      end else begin
         fifo_rd_en_o   <= 1'b0;
         sample_valid_o <= 1'b0;

         unique case (state)
            IDLE: begin
               if (start) begin
                  state        <= READ;
                  fifo_rd_en_o <= 1'b1;
                  busy_o       <= 1'b1;
               end else if (starve) begin
                  underrun_o <= 1'b1;
               end
            end

            READ: begin
               state <= WAIT;
            end

            WAIT: begin
               // FIFO data is valid now; load it and drive the MSB
               state          <= SHIFT;
               shreg          <= fifo_data_i;
               sample_o       <= fifo_data_i;
               sample_valid_o <= 1'b1;
               cs_n_o         <= 1'b0;
               sclk_o         <= 1'b0;
               sdo_o          <= fifo_data_i[DATA_WIDTH-1];
               phase          <= '0;
               bit_cnt        <= BIT_MSB;
            end

            SHIFT: begin
               if (phase == PH_LAST) begin
                  phase  <= '0;
                  sclk_o <= 1'b0;
                  if (bit_cnt == BIT_LSB) begin
                     state      <= GAP;
                     cs_n_o     <= 1'b1;
                     sdo_o      <= 1'b0;
                     frame_sent <= 1'b1;
                  end else begin
                     // next bit appears while sclk is low
                     bit_cnt <= bit_cnt - 1'b1;
                     shreg   <= shreg << 1;
                     sdo_o   <= shreg[DATA_WIDTH-2];
                  end
               end else begin
                  phase <= phase + 1'b1;
                  if (phase == PH_RISE) begin
                     sclk_o <= 1'b1;
                  end
               end
            end

            GAP: begin
               if (phase == GAP_LAST) begin
                  state  <= IDLE;
                  phase  <= '0;
                  busy_o <= 1'b0;
                  // flag starvation already in the first IDLE cycle
                  if (starve) begin
                     underrun_o <= 1'b1;
                  end
               end else begin
                  phase <= phase + 1'b1;
               end
            end

            default: begin
               state  <= IDLE;
               busy_o <= 1'b0;
               cs_n_o <= 1'b1;
               sclk_o <= 1'b0;
               sdo_o  <= 1'b0;
            end
         endcase

         // disabling clears the flag and the frame history
         if (en_low_i) begin
            underrun_o <= 1'b0;
            frame_sent <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fifo_dac_reader.sv
// tb_fifo_dac_reader: directed bench with a frame-timeline model,
// a FIFO model driven by the DUT pop pulse, and a serial DAC capture.

module tb_fifo_dac_reader;

   localparam int W      = 16;
   localparam int DIV    = 2;
   localparam int SH_END = 3 + 2 * DIV * W;
   localparam int PERIOD = SH_END + DIV;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic en_low = 1'b1;
   logic fifo_empty = 1'b1;
   logic [W-1:0] fifo_data = '0;

   logic rd_en, cs_n, sclk, sdo, sval, busy, under;
   logic signed [W-1:0] sample;

   always #5 clk = ~clk;

   fifo_dac_reader #(
      .DATA_WIDTH(W),
      .DIV(DIV)
   ) dut (
      .clk(clk),
      .rst(rst),
      .en_low_i(en_low),
      .fifo_empty_i(fifo_empty),
      .fifo_data_i(fifo_data),
      .fifo_rd_en_o(rd_en),
      .cs_n_o(cs_n),
      .sclk_o(sclk),
      .sdo_o(sdo),
      .sample_o(sample),
      .sample_valid_o(sval),
      .busy_o(busy),
      .underrun_o(under)
   );

   int total = 0;
   int bad = 0;
   int cyc = 0;

   logic [W-1:0] fq[$];
   logic [W-1:0] pq[$];

   // model: a frame is a timeline t = cycles since the start cycle
   logic         m_act = 1'b0;
   int           m_t = 0;
   logic         m_sent = 1'b0;
   logic [W-1:0] m_word = '0;
   logic [W-1:0] e_sample = '0;
   logic         e_under = 1'b0;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (cyc %0d)", nm, act, exp, cyc);
      end
   endtask

   // model update first, then the FIFO that answers the DUT
   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         m_act = 1'b0;
         m_t = 0;
         m_sent = 1'b0;
         e_under = 1'b0;
         e_sample = '0;
      end else begin
         if (en_low) begin
            m_sent = 1'b0;
            e_under = 1'b0;
         end
         if (m_act) begin
            m_t++;
            if (m_t == SH_END && !en_low) m_sent = 1'b1;
            if (m_t == PERIOD) m_act = 1'b0;
         end else if (!en_low && !fifo_empty) begin
            m_act = 1'b1;
            m_t = 1;
            m_word = fq[0];
         end
         if (!m_act && !en_low && fifo_empty && m_sent) e_under = 1'b1;
         if (m_act && m_t == 3) e_sample = m_word;
      end
      if (rd_en === 1'b1 && fq.size() > 0) begin
         fifo_data <= fq[0];
         fq.delete(0);
      end
      while (pq.size() > 0) begin
         fq.push_back(pq[0]);
         pq.delete(0);
      end
      fifo_empty <= (fq.size() == 0);
   end

   logic sh;
   int   k;
   logic esclk;
   logic esdo;

   always @(negedge clk) begin
      if (cyc > 0) begin
         if (rst) begin
            chk("rst_rd_en", rd_en, 0);
            chk("rst_cs_n", cs_n, 1);
            chk("rst_sclk", sclk, 0);
            chk("rst_sdo", sdo, 0);
            chk("rst_sample", $unsigned(sample), 0);
            chk("rst_valid", sval, 0);
            chk("rst_busy", busy, 0);
            chk("rst_underrun", under, 0);
         end else begin
            sh = m_act && m_t >= 3 && m_t < SH_END;
            k = m_t - 3;
            esclk = 1'b0;
            esdo = 1'b0;
            if (sh) begin
               esclk = (k % (2 * DIV)) >= DIV;
               esdo = m_word[W - 1 - k / (2 * DIV)];
            end
            chk("rd_en", rd_en, 32'(m_act && m_t == 1));
            chk("cs_n", cs_n, 32'(!sh));
            chk("sclk", sclk, 32'(esclk));
            chk("sdo", sdo, 32'(esdo));
            chk("sample", $unsigned(sample), e_sample);
            chk("valid", sval, 32'(m_act && m_t == 3));
            chk("busy", busy, 32'(m_act));
            chk("underrun", under, 32'(e_under));
         end
      end
   end

   // DAC capture on sclk rising edges; keep only complete frames
   logic [W-1:0] cap = '0;
   int           nb = 0;
   logic [W-1:0] caps[$];
   int           lowcnt = 0;
   int           lowq[$];
   int           rd_times[$];

   always @(posedge sclk) begin
      if (cs_n === 1'b0) begin
         cap = {cap[W-2:0], sdo};
         nb++;
      end
   end

   always @(negedge cs_n) begin
      nb = 0;
      lowcnt = 0;
   end

   always @(posedge cs_n) begin
      if (nb == W) caps.push_back(cap);
      if (lowcnt > 0) lowq.push_back(lowcnt);
   end

   always @(negedge clk) begin
      if (cs_n === 1'b0) lowcnt++;
      if (rd_en === 1'b1) rd_times.push_back(cyc);
   end

   function automatic logic [31:0] capw(int i);
      return (i < caps.size()) ? 32'(caps[i]) : 32'hDEAD_BEEF;
   endfunction

   task automatic tick(int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic push(logic [W-1:0] v);
      pq.push_back(v);
   endtask

   initial begin
      #1 rst = 1'b1;
      for (int i = 0; i < 6; i++) begin
         en_low = 1'($urandom);
         tick(1);
      end
      en_low = 1'b0;
      rst = 1'b0;
      tick(10);
      chk("idle_no_read", rd_times.size(), 0);
      chk("idle_no_underrun", under, 0);

      // single sample
      push(16'hA5C3);
      tick(2);
      chk("t1_rd_en", rd_en, 1);
      tick(2);
      chk("t3_valid", sval, 1);
      chk("t3_sample", $unsigned(sample), 16'hA5C3);
      chk("t3_cs_n", cs_n, 0);
      chk("t3_msb", sdo, 1);
      chk("t3_sclk", sclk, 0);
      tick(2);
      chk("t5_sclk", sclk, 1);
      tick(70);
      chk("single_reads", rd_times.size(), 1);
      chk("single_cs_low", (lowq.size() > 0) ? lowq[0] : -1, 64);
      chk("single_word", capw(0), 16'hA5C3);
      chk("underrun_set", under, 1);
      push(16'h1234);
      tick(75);
      chk("underrun_sticky", under, 1);
      chk("sticky_word", capw(1), 16'h1234);
      en_low = 1'b1;
      tick(2);
      chk("underrun_clear", under, 0);

      // back to back
      rd_times.delete();
      push(16'h7FFF);
      push(16'h8000);
      tick(2);
      en_low = 1'b0;
      tick(150);
      chk("b2b_reads", rd_times.size(), 2);
      if (rd_times.size() == 2)
         chk("b2b_period", rd_times[1] - rd_times[0], 69);
      chk("b2b_word0", capw(2), 16'h7FFF);
      chk("b2b_word1", capw(3), 16'h8000);
      chk("b2b_signed", 32'(sample), 32'hFFFF_8000);
      en_low = 1'b1;
      tick(2);

      // disable mid-frame at bit 8
      rd_times.delete();
      push(16'h1111);
      push(16'h2222);
      push(16'h3333);
      tick(2);
      en_low = 1'b0;
      tick(35);
      en_low = 1'b1;
      tick(80);
      chk("dis_reads", rd_times.size(), 1);
      chk("dis_left", fq.size(), 2);
      chk("dis_word", capw(4), 16'h1111);

      // reset mid-frame in the high half of bit 5
      en_low = 1'b0;
      tick(25);
      chk("pre_rst_cs_n", cs_n, 0);
      chk("pre_rst_sclk", sclk, 1);
      #2 rst = 1'b1;
      #1;
      chk("rst_now_cs_n", cs_n, 1);
      chk("rst_now_sclk", sclk, 0);
      tick(3);
      rst = 1'b0;
      tick(80);
      chk("rst_frames", caps.size(), 6);
      chk("rst_word", capw(5), 16'h3333);
      chk("rst_fifo_drained", fq.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fifo_dac_reader.md
# fifo_dac_reader

Read-side consumer for the generator FIFO. When enabled and the FIFO holds data, it pops one signed sample, latches it, and shifts it MSB-first to an external serial DAC over a chip-select/clock/data frame. It then returns to idle and repeats, draining the samples that `funct_generator` writes through `wr_en_o`/`data_o`.

## Interface
- `DATA_WIDTH`, 16: sample width; must match the generator/FIFO data width.
- `DIV`, 2: half-period of `sclk_o` in `clk` cycles; legal range is ≥1.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `en_low_i`  in  1  active-low enable; 0 = run, 1 = stop after the current frame.
- `fifo_empty_i`  in  1  FIFO empty flag.
- `fifo_data_i`  in  DATA_WIDTH  FIFO read data; valid on the cycle after `fifo_rd_en_o`.
- `fifo_rd_en_o`  out  1  FIFO pop request; one-cycle pulse per sample.
- `cs_n_o`  out  1  DAC chip select, active-low.
- `sclk_o`  out  1  DAC serial clock; the DAC samples on the rising edge.
- `sdo_o`  out  1  DAC serial data, MSB first.
- `sample_o`  out  DATA_WIDTH (signed)  last sample popped.
- `sample_valid_o`  out  1  one-cycle pulse when `sample_o` updates.
- `busy_o`  out  1  high in every state except IDLE.
- `underrun_o`  out  1  sticky stream-starvation flag.

## Operation
- All outputs are registered.
- Reset values: `fifo_rd_en_o`=0, `cs_n_o`=1, `sclk_o`=0, `sdo_o`=0, `sample_o`=0, `sample_valid_o`=0, `busy_o`=0, `underrun_o`=0. State is IDLE and all counters are 0.
- FSM states: IDLE, READ, WAIT, SHIFT, GAP.
- IDLE → READ when `en_low_i`=0 and `fifo_empty_i`=0.
  - `fifo_rd_en_o`=1 during READ only.
  - A read is never issued while `fifo_empty_i`=1.
- READ → WAIT unconditionally (FIFO data becomes valid in WAIT).
- WAIT → SHIFT unconditionally. On this edge, `fifo_data_i` is captured into the shift register and into `sample_o`, and `sample_valid_o` pulses high for the first SHIFT cycle.
- SHIFT:
  - `cs_n_o`=0.
  - Each bit is held for 2·DIV cycles: `sclk_o`=0 for the first DIV cycles, then 1 for the next DIV cycles.
  - `sdo_o` changes only while `sclk_o` is low, at the start of each bit.
  - Bit order: `DATA_WIDTH-1` down to 0.
  - After the high half of bit 0 → GAP.
- GAP: `cs_n_o`=1, `sclk_o`=0, `sdo_o`=0 for DIV cycles, then → IDLE.
- `en_low_i` going to 1 mid-frame does not abort the frame; the FSM completes SHIFT/GAP and then holds in IDLE.
- `fifo_empty_i` is ignored outside IDLE.
- `underrun_o` behaviour:
  - Set when in IDLE with `en_low_i`=0, `fifo_empty_i`=1, and at least one frame already sent since enable.
  - Cleared only by `rst` or `en_low_i`=1.
  - The "frame sent" history also clears on `en_low_i`=1.
- `rst` asserted mid-frame immediately forces all reset values: `cs_n_o` rises and no partial frame resumes. The sample in flight is lost.
- Arithmetic: the bit counter is `$clog2(DATA_WIDTH)` bits and the phase counter is `$clog2(2·DIV)` bits. Both wrap only under FSM control.

## Timing
- Call T0 the IDLE cycle in which the start condition is sampled true.
  - T1: READ.
  - T2: WAIT.
  - T3: first SHIFT cycle, with `cs_n_o` low, MSB on `sdo_o`, and `sample_valid_o`=1.
- First `sclk_o` rising edge occurs at T3+DIV.
- SHIFT lasts 2·DIV·DATA_WIDTH cycles; GAP lasts DIV cycles.
- Back-to-back frames (FIFO never empty): start-to-start period = 3 + 2·DIV·DATA_WIDTH + DIV cycles. With the defaults this is 69 cycles.
- Maximum sustained rate is one sample per period. The upstream write rate must not exceed this, or the FIFO fills.

## Test plan
- Reset: hold `rst`=1 with random inputs → all outputs at their reset values. Release `rst` with FIFO empty and `en_low_i`=0 → `fifo_rd_en_o` stays 0 and `underrun_o` stays 0.
- Single sample: push 16'hA5C3 and set `en_low_i`=0.
  - `fifo_rd_en_o` pulses once.
  - `sample_o`=16'hA5C3 with `sample_valid_o` at T3.
  - A DAC model capturing on `sclk_o` rising edges receives 1010_0101_1100_0011.
  - `cs_n_o` is low for exactly 64 cycles.
- Back-to-back: push 16'h7FFF and 16'h8000 → two frames with start-to-start of 69 cycles; captured values are 0x7FFF and 0x8000 (signed −32768).
- Disable mid-frame: set `en_low_i`=1 at bit 8 of frame 1 with 3 samples queued → frame 1 completes intact, then no further `fifo_rd_en_o` and 2 samples remain in the FIFO.
- Reset mid-frame: assert `rst` at bit 5 → same cycle `cs_n_o`=1 and `sclk_o`=0. After release with data queued, the next frame carries a fresh sample, MSB first.
- Underrun: send one sample, then leave the FIFO empty with `en_low_i`=0.
  - `underrun_o`=1 in the first IDLE cycle after GAP and stays 1 after a new push.
  - Clears when `en_low_i`=1.
